// File: rtl/nncore_pkg.sv
// Shared types for the spike event path: event descriptor and output slot state.
// SPIKE_ARB_TIMESTAMP_EN adds a capture-time field to the event descriptor.
package nncore_pkg;

    // Widest address/timestamp an event can carry; instances slice down to their own widths.
    localparam int unsigned SPIKE_ADDR_W = 8;
`ifdef SPIKE_ARB_TIMESTAMP_EN
    localparam int unsigned SPIKE_TS_W = 32;
`endif

    typedef struct packed {
`ifdef SPIKE_ARB_TIMESTAMP_EN
        logic [SPIKE_TS_W-1:0]   ts;
`endif
        logic [SPIKE_ADDR_W-1:0] addr;
    } spike_event_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/spike_event_arbiter_if.sv
// Valid/ready address-event link from the spike arbiter to the event router.
// SPIKE_ARB_TIMESTAMP_EN adds the event_ts signal and its TS_WIDTH parameter.
interface spike_event_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 4
`ifdef SPIKE_ARB_TIMESTAMP_EN
    ,
    parameter int unsigned TS_WIDTH   = 16
`endif
);
    logic                  event_valid;
    logic                  event_ready;
    logic [ADDR_WIDTH-1:0] event_addr;
`ifdef SPIKE_ARB_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]   event_ts;
`endif

    modport master (
        output event_valid,
        output event_addr,
`ifdef SPIKE_ARB_TIMESTAMP_EN
        output event_ts,
`endif
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_addr,
`ifdef SPIKE_ARB_TIMESTAMP_EN
        input  event_ts,
`endif
        output event_ready
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping at N-1.
module rr_arbiter #(
    parameter int unsigned N = 16,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         grant_valid
);

    logic [W:0]   pos;
    logic [W-1:0] idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        pos         = '0;
        idx         = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (W+1)'(k);
            if (pos >= (W+1)'(N)) pos = pos - (W+1)'(N);
            idx = pos[W-1:0];
            if (!grant_valid && req[idx]) begin
                grant_valid    = 1'b1;
                grant_idx      = idx;
                grant[idx]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spike_event_arbiter.sv
// Captures spike pulses into pending bits and serialises them as address events.
// SPIKE_ARB_TIMESTAMP_EN adds a free-running timestamp latched per neuron at capture.
module spike_event_arbiter
    import nncore_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = 16,
    parameter int unsigned ADDR_WIDTH  = $clog2(NUM_NEURONS),
    parameter int unsigned DROP_WIDTH  = 16,
    parameter int unsigned TS_WIDTH    = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_NEURONS-1:0]       spike_in,
    input  logic                         arb_enable,
    spike_event_arbiter_if.master        evt,
    output logic [DROP_WIDTH-1:0]        drop_count,
    output logic                         pending_any
);

    localparam int unsigned IDX_W = $clog2(NUM_NEURONS);
    localparam int unsigned SUM_W = DROP_WIDTH + 9;

    if (NUM_NEURONS < 2 || NUM_NEURONS > 256 || ADDR_WIDTH < IDX_W ||
        ADDR_WIDTH > SPIKE_ADDR_W || TS_WIDTH < 1 || TS_WIDTH > 32) begin : g_param_err
        $error("spike_event_arbiter: unsupported parameter combination");
    end

    logic [NUM_NEURONS-1:0] pend_q, pend_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    out_state_e             state_q, state_d;
    spike_event_t           evt_q, evt_d;
    logic [DROP_WIDTH-1:0]  drop_d;

    logic [NUM_NEURONS-1:0] gnt_oh, gnt_mask, dropped;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   gnt_valid, slot_free, grant;
    logic [8:0]             drop_inc;
    logic [SUM_W-1:0]       drop_sum;

    rr_arbiter #(
        .N (NUM_NEURONS),
        .W (IDX_W)
    ) u_rr_arbiter (
        .req         (pend_q),
        .ptr         (rr_ptr_q),
        .grant       (gnt_oh),
        .grant_idx   (gnt_idx),
        .grant_valid (gnt_valid)
    );

    // Slot decision uses only registered state plus ready, so valid never sees ready.
    assign slot_free = (state_q == EMPTY) || evt.event_ready;
    assign grant     = arb_enable && gnt_valid && slot_free;
    assign gnt_mask  = grant ? gnt_oh : '0;
    assign pend_d    = (pend_q & ~gnt_mask) | spike_in;
    assign dropped   = spike_in & pend_q & ~gnt_mask;
    assign rr_ptr_d  = !grant ? rr_ptr_q :
                       (gnt_idx == IDX_W'(NUM_NEURONS - 1)) ? '0 : gnt_idx + IDX_W'(1);

    always_comb begin
        drop_inc = '0;
        for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
            drop_inc = drop_inc + 9'(dropped[i]);
        end
        drop_sum = SUM_W'(drop_count) + SUM_W'(drop_inc);
        drop_d   = (drop_sum > SUM_W'({DROP_WIDTH{1'b1}})) ? '1 : drop_sum[DROP_WIDTH-1:0];
    end

`ifdef SPIKE_ARB_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_cnt_q;
    logic [TS_WIDTH-1:0] ts_q [NUM_NEURONS];

    // A spike arriving on a freshly granted neuron starts a new event, so it re-latches too.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt_q <= '0;
            for (int unsigned i = 0; i < NUM_NEURONS; i++) ts_q[i] <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + TS_WIDTH'(1);
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                if (spike_in[i] && (!pend_q[i] || gnt_mask[i])) ts_q[i] <= ts_cnt_q;
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        evt_d   = evt_q;
        if (grant) begin
            state_d    = FULL;
            evt_d.addr = SPIKE_ADDR_W'(gnt_idx);
`ifdef SPIKE_ARB_TIMESTAMP_EN
            evt_d.ts   = SPIKE_TS_W'(ts_q[gnt_idx]);
`endif
        end else if (state_q == FULL && evt.event_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q      <= '0;
            rr_ptr_q    <= '0;
            state_q     <= EMPTY;
            evt_q       <= '0;
            drop_count  <= '0;
            pending_any <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            rr_ptr_q    <= rr_ptr_d;
            state_q     <= state_d;
            evt_q       <= evt_d;
            drop_count  <= drop_d;
            pending_any <= |pend_d;
        end
    end

    assign evt.event_valid = (state_q == FULL);
    assign evt.event_addr  = evt_q.addr[ADDR_WIDTH-1:0];
`ifdef SPIKE_ARB_TIMESTAMP_EN
    assign evt.event_ts    = evt_q.ts[TS_WIDTH-1:0];
`endif

    // Descriptor fields are sized for the widest instance; narrower ones leave top bits idle.
    logic unused_evt_bits;
    assign unused_evt_bits = ^evt_q;

endmodule

// File: tb/tb_spike_event_arbiter.sv
// Directed bench for spike_event_arbiter with a per-cycle behavioural reference model.
module tb_spike_event_arbiter;

    localparam int N  = 16;
    localparam int AW = 4;
    localparam int DW = 4;
    localparam int DROP_MAX = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  spike_in = '0;
    logic          arb_enable = 1'b0;
    logic [DW-1:0] drop_count;
    logic          pending_any;

    spike_event_arbiter_if #(.ADDR_WIDTH(AW)) evt ();

    spike_event_arbiter #(
        .NUM_NEURONS (N),
        .ADDR_WIDTH  (AW),
        .DROP_WIDTH  (DW),
        .TS_WIDTH    (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .spike_in    (spike_in),
        .arb_enable  (arb_enable),
        .evt         (evt),
        .drop_count  (drop_count),
        .pending_any (pending_any)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: set of pending neurons, round-robin cursor, one output slot.
    bit m_pend [N];
    int m_ptr;
    bit m_valid;
    int m_addr;
    int m_drop;
    bit m_pany;

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_ptr   = 0;
        m_valid = 1'b0;
        m_addr  = 0;
        m_drop  = 0;
        m_pany  = 1'b0;
    endtask

    task automatic model_step();
        int g;
        int cnt;
        bit found;
        bit take;
        bit hit;
        found = 1'b0;
        g     = 0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (!found && m_pend[j]) begin
                found = 1'b1;
                g     = j;
            end
        end
        take = arb_enable && found && (!m_valid || evt.event_ready);
        cnt  = 0;
        for (int i = 0; i < N; i++) begin
            hit = take && (i == g);
            if (spike_in[i] && m_pend[i] && !hit) cnt++;
            m_pend[i] = (m_pend[i] && !hit) || spike_in[i];
        end
        m_drop = (m_drop + cnt > DROP_MAX) ? DROP_MAX : m_drop + cnt;
        if (take) begin
            m_valid = 1'b1;
            m_addr  = g;
            m_ptr   = (g + 1) % N;
        end else if (m_valid && evt.event_ready) begin
            m_valid = 1'b0;
        end
        m_pany = 1'b0;
        for (int i = 0; i < N; i++) m_pany = m_pany | m_pend[i];
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                chk("model_valid", evt.event_valid, m_valid);
                if (m_valid) chk("model_addr", evt.event_addr, m_addr);
                chk("model_drop", drop_count, m_drop);
                chk("model_pending_any", pending_any, m_pany);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        step();
        reset_n  = 1'b0;
        spike_in = '0;
        step();
        reset_n  = 1'b1;
    endtask

    initial begin
        evt.event_ready = 1'b0;
        repeat (2) step();
        chk("reset_valid", evt.event_valid, 0);
        chk("reset_addr", evt.event_addr, 0);
        chk("reset_drop", drop_count, 0);
        chk("reset_pending_any", pending_any, 0);
        reset_n = 1'b1;

        // Single spike: two-cycle latency, then slot empties.
        arb_enable      = 1'b1;
        evt.event_ready = 1'b1;
        spike_in        = 16'h0004;
        step();
        spike_in = '0;
        chk("single_t1_valid", evt.event_valid, 0);
        chk("single_t1_pending", pending_any, 1);
        step();
        chk("single_t2_valid", evt.event_valid, 1);
        chk("single_t2_addr", evt.event_addr, 2);
        step();
        chk("single_t3_valid", evt.event_valid, 0);

        // Burst: all sixteen in order, one per cycle.
        do_reset();
        spike_in = 16'hFFFF;
        step();
        spike_in = '0;
        for (int k = 0; k < N; k++) begin
            step();
            chk("burst_valid", evt.event_valid, 1);
            chk("burst_addr", evt.event_addr, k);
            if (k == N - 2) chk("burst_pending_mid", pending_any, 1);
        end
        chk("burst_pending_end", pending_any, 0);
        step();
        chk("burst_after_valid", evt.event_valid, 0);

        // Backpressure then round-robin from pointer 4.
        do_reset();
        evt.event_ready = 1'b0;
        spike_in        = 16'h1208;
        step();
        spike_in = '0;
        chk("bp_first_valid", evt.event_valid, 0);
        step();
        chk("bp_load_addr", evt.event_addr, 3);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_hold_valid", evt.event_valid, 1);
            chk("bp_hold_addr", evt.event_addr, 3);
        end
        evt.event_ready = 1'b1;
        step();
        chk("rr_next_addr", evt.event_addr, 9);
        step();
        chk("rr_last_addr", evt.event_addr, 12);
        step();
        chk("rr_done_valid", evt.event_valid, 0);
        chk("rr_done_pending", pending_any, 0);

        // Drop while disabled, then spike colliding with its own grant.
        do_reset();
        arb_enable = 1'b0;
        spike_in   = 16'h0020;
        step();
        step();
        spike_in = '0;
        chk("drop_count_one", drop_count, 1);
        step();
        chk("drop_disabled_valid", evt.event_valid, 0);
        arb_enable = 1'b1;
        spike_in   = 16'h0020;
        step();
        spike_in = '0;
        chk("coll_valid", evt.event_valid, 1);
        chk("coll_addr", evt.event_addr, 5);
        chk("coll_pending", pending_any, 1);
        chk("coll_drop", drop_count, 1);
        step();
        chk("coll_second_addr", evt.event_addr, 5);
        chk("coll_second_pending", pending_any, 0);
        chk("coll_second_drop", drop_count, 1);
        step();
        chk("coll_end_valid", evt.event_valid, 0);

        // Drop counter saturation at all-ones.
        do_reset();
        arb_enable = 1'b0;
        spike_in   = 16'hFFFF;
        step();
        chk("sat_first_drop", drop_count, 0);
        step();
        chk("sat_drop", drop_count, 15);
        step();
        chk("sat_hold_drop", drop_count, 15);
        spike_in = '0;

        // Asynchronous reset while FULL with four pending.
        do_reset();
        arb_enable      = 1'b1;
        evt.event_ready = 1'b0;
        spike_in        = 16'h001F;
        step();
        spike_in = '0;
        step();
        chk("rst_pre_valid", evt.event_valid, 1);
        chk("rst_pre_addr", evt.event_addr, 0);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_async_valid", evt.event_valid, 0);
        chk("rst_async_pending", pending_any, 0);
        step();
        reset_n         = 1'b1;
        evt.event_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rst_after_valid", evt.event_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_event_arbiter.md
# spike_event_arbiter

Collects single-cycle spike pulses from an array of `neuron` instances and serialises them into a stream of address events for the downstream event router. One pending bit per neuron absorbs bursts. A round-robin arbiter selects one pending neuron per cycle. The winning address is presented on a valid/ready output register.

## Interface
- `NUM_NEURONS`, default 16: number of spike inputs; legal range 2..256.
- `ADDR_WIDTH`, default `$clog2(NUM_NEURONS)`: event address width.
- `DROP_WIDTH`, default 16: width of the saturating drop counter.
- `TS_WIDTH`, default 16: timestamp width; used only with `SPIKE_ARB_TIMESTAMP_EN`.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `spike_in` in NUM_NEURONS: one pulse per spike, bit i from neuron i.
- `arb_enable` in 1: when 0, spikes are still captured but no grants are issued.
- `event_valid` out 1: output register holds an event.
- `event_ready` in 1: consumer accepts the event this cycle.
- `event_addr` out ADDR_WIDTH: index of the spiking neuron.
- `event_ts` out TS_WIDTH: spike capture time; present only with the macro.
- `drop_count` out DROP_WIDTH: number of spikes lost, saturating.
- `pending_any` out 1: OR of all pending bits.

## Operation
- Pending vector `pend[NUM_NEURONS]`:
  - Set by `spike_in[i]`.
  - Cleared when neuron i is granted.
  - If spike and grant for the same i occur in the same cycle, the bit stays set; this is a new event, not a drop.
- Drop rule:
  - A spike on i while `pend[i]`=1 and i is not granted that cycle increments `drop_count` by the number of such bits that cycle.
  - The increment saturates at all-ones.
- Grant condition: `arb_enable`=1, `pend` non-zero, and the output slot is free.
  - The slot is free when state is EMPTY, or when state is FULL and `event_ready`=1.
- Round-robin selection:
  - Pointer `rr_ptr` resets to 0.
  - Search starts at `rr_ptr` and wraps at NUM_NEURONS-1 → 0.
  - After granting g: `rr_ptr` = g+1, wrapping to 0 when g = NUM_NEURONS-1.
  - `rr_ptr` is unchanged when there is no grant.
- Output FSM:
  - EMPTY: `event_valid`=0. On a grant → FULL, loading the address.
  - FULL: `event_valid`=1 and `event_addr` stable.
    - `event_ready`=1 with a grant: reload; stay FULL (back-to-back, one event per cycle).
    - `event_ready`=1 without a grant: → EMPTY.
    - `event_ready`=0: hold.
- Deasserting `arb_enable` does not retract an event already in FULL; it still completes its handshake.
- Reset values: `pend`=0, `rr_ptr`=0, state EMPTY, `event_valid`=0, `event_addr`=0, `event_ts`=0, `drop_count`=0, `pending_any`=0.
- Reset mid-operation discards all pending and in-flight events immediately; nothing is replayed after release.

## Timing
- Spike on i in cycle t sets `pend[i]` at the end of t.
- The earliest grant is in cycle t+1, so `event_valid` rises in cycle t+2: latency 2 cycles.
- Sustained throughput is 1 event per cycle while `event_ready`=1.
- Fairness: a pending neuron is granted within NUM_NEURONS grants.
- `pending_any` and `drop_count` are registered and reflect the state after the current edge.
- `event_valid` must never depend combinationally on `event_ready`.

## Configuration
- Macro `SPIKE_ARB_TIMESTAMP_EN`, defined:
  - A free-running `TS_WIDTH` counter (reset 0, wraps) is added.
  - Per-neuron timestamp registers latch the counter when `pend[i]` goes 0→1.
  - `event_ts` carries the winner's latched timestamp alongside `event_addr`.
- Undefined:
  - The counter, the timestamp registers and the `event_ts` port are absent.
  - All other behaviour is identical.

## Structure
- Shared package `nncore_pkg` holds:
  - the `spike_event_t` struct (addr, plus ts under the macro);
  - the output FSM state enum (EMPTY, FULL).
- Sub-module `rr_arbiter`: combinational, parameterised by N.
  - Inputs: request vector and `rr_ptr`.
  - Outputs: one-hot grant, encoded index and `grant_valid`.
- The pending vector, pointer, FSM and drop counter live in `spike_event_arbiter`.

## Test plan
- Single spike: `spike_in`=0x0004 in cycle 0, `event_ready`=1 → `event_valid` in cycle 2 with addr 2, then `event_valid`=0.
- Burst: `spike_in`=0xFFFF in one cycle, `event_ready`=1 → addresses 0,1,…,15 on 16 consecutive cycles, then `pending_any`=0.
- Backpressure and fairness:
  - Hold `event_ready`=0 for 5 cycles with addr 3 presented → addr stays 3 and valid stays 1.
  - Release with `pend`={3,9,12}, `rr_ptr`=4 → next events are 9, then 12.
- Drop and collision:
  - Spike on 5 twice before it is granted, with `arb_enable`=0 → `drop_count`=1.
  - Spike on 5 in the same cycle as its grant → a second event for 5, `drop_count` unchanged.
- Reset mid-stream: assert `reset_n`=0 asynchronously while FULL with 4 pending → `event_valid`=0 immediately and no events after release.
- Timestamp (with the macro): spikes on 7 at ts=10 and on 1 at ts=12 → events (1,12)/(7,10) issued in round-robin order, each with its own capture time.
